// File: rtl/alu_pkg.sv
// Shared types for the ALU/MDU: op codes, FSM states and op-decode helpers.
package alu_pkg;

  localparam int unsigned OpCodeW = 5;

  typedef enum logic [OpCodeW-1:0] {
    OpAdd    = 5'd0,
    OpSub    = 5'd1,
    OpSll    = 5'd2,
    OpSlt    = 5'd3,
    OpSltu   = 5'd4,
    OpXor    = 5'd5,
    OpSrl    = 5'd6,
    OpSra    = 5'd7,
    OpOr     = 5'd8,
    OpAnd    = 5'd9,
    OpMul    = 5'd16,
    OpMulh   = 5'd17,
    OpMulhsu = 5'd18,
    OpMulhu  = 5'd19,
    OpDiv    = 5'd20,
    OpDivu   = 5'd21,
    OpRem    = 5'd22,
    OpRemu   = 5'd23
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  function automatic logic is_muldiv(input logic [OpCodeW-1:0] op);
    return op[4];
  endfunction

  // Codes outside the defined set behave as ADD.
  function automatic op_e decode_op(input logic [OpCodeW-1:0] op);
    if (op <= 5'd9 || (is_muldiv(op) && !op[3])) begin
      return op_e'(op);
    end
    return OpAdd;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide core: one shared adder and a {hi,lo} shift pair.
// Multiply is shift-add (LSB first), divide is restoring (MSB first); XLEN steps each.
module mdu_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic            div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            last_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic            div_q, div_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [XLEN:0]   add_a, add_b;
  logic [XLEN+1:0] sum;
  logic            ge;
  logic [XLEN-1:0] step_hi, step_lo;

  always_comb begin
    add_a = div_q ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
    add_b = div_q ? ~{1'b0, b_q} : (lo_q[0] ? {1'b0, b_q} : '0);
    sum   = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, div_q};
    // Carry out of (partial remainder - divisor) means no borrow: quotient bit is 1.
    ge    = sum[XLEN+1];
    if (div_q) begin
      step_hi = ge ? sum[XLEN-1:0] : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
      step_lo = {lo_q[XLEN-2:0], ge};
    end else begin
      step_hi = sum[XLEN:1];
      step_lo = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      hi_d  = '0;
      lo_d  = '0;
      cnt_d = '0;
    end else if (start_i) begin
      hi_d  = '0;
      lo_d  = a_i;
      b_d   = b_i;
      div_d = div_i;
      cnt_d = CntW'(XLEN);
    end else if (cnt_q != '0) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs are the values the final step produces, so the caller can register them directly.
  assign last_o = (cnt_q == CntW'(1));
  assign hi_o   = step_hi;
  assign lo_o   = step_lo;

endmodule

// File: rtl/alu_mdu.sv
// RV32I ALU plus RV32M multiply/divide behind a valid/ready handshake.
// Build option ALU_FAST_MUL_EN: single-cycle combinational multiplier instead of iterative MUL.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned ShW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  op_e             mop_q, mop_d;
  logic            neg_q, neg_d;

  op_e             op_dec;
  logic            is_md, is_div, is_rem, signed_a, signed_b, neg_a, neg_b;
  logic            div_zero, div_ovf, iter_needed, start;
  logic [XLEN-1:0] mag_a, mag_b, base_res, imm_res;
  logic [ShW-1:0]  shamt;

  logic            iter_last;
  logic [XLEN-1:0] iter_hi, iter_lo, fix_res;
  logic [2*XLEN-1:0] prod_mag, prod_fix;

  assign op_dec = decode_op(op[OpCodeW-1:0]);
  assign is_md  = is_muldiv(op_dec);
  assign is_div = (op_dec == OpDiv) || (op_dec == OpDivu) || (op_dec == OpRem) ||
                  (op_dec == OpRemu);
  assign is_rem = (op_dec == OpRem) || (op_dec == OpRemu);
  assign shamt  = src2[ShW-1:0];

  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (op_dec)
      OpMul, OpMulh, OpDiv, OpRem: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      OpMulhsu: signed_a = 1'b1;
      default: ;
    endcase
  end

  assign neg_a    = signed_a & src1[XLEN-1];
  assign neg_b    = signed_b & src2[XLEN-1];
  assign mag_a    = neg_a ? -src1 : src1;
  assign mag_b    = neg_b ? -src2 : src2;
  assign div_zero = (src2 == '0);
  assign div_ovf  = ((op_dec == OpDiv) || (op_dec == OpRem)) && (src1 == MinNeg) &&
                    (src2 == '1);

  always_comb begin
    base_res = src1 + src2;
    case (op_dec)
      OpSub:   base_res = src1 - src2;
      OpSll:   base_res = src1 << shamt;
      OpSlt:   base_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
      OpSltu:  base_res = {{(XLEN-1){1'b0}}, src1 < src2};
      OpXor:   base_res = src1 ^ src2;
      OpSrl:   base_res = src1 >> shamt;
      OpSra:   base_res = $unsigned($signed(src1) >>> shamt);
      OpOr:    base_res = src1 | src2;
      OpAnd:   base_res = src1 & src2;
      default: ;
    endcase
  end

`ifdef ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{neg_a}}, src1} * {{XLEN{neg_b}}, src2};
  assign iter_needed = is_div && !div_zero && !div_ovf;
`else
  assign iter_needed = is_md && !(is_div && (div_zero || div_ovf));
`endif

  // Results that complete in one cycle: base ops, divide corner cases, fast multiply.
  always_comb begin
    imm_res = base_res;
    if (is_div) begin
      if (div_zero)     imm_res = is_rem ? src1 : '1;
      else if (div_ovf) imm_res = is_rem ? '0 : src1;
    end
`ifdef ALU_FAST_MUL_EN
    else if (is_md) begin
      imm_res = (op_dec == OpMul) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  always_comb begin
    prod_mag = {iter_hi, iter_lo};
    prod_fix = neg_q ? -prod_mag : prod_mag;
    case (mop_q)
      OpMul:                     fix_res = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fix_res = prod_fix[2*XLEN-1:XLEN];
      OpRem, OpRemu:             fix_res = neg_q ? -iter_hi : iter_hi;
      default:                   fix_res = neg_q ? -iter_lo : iter_lo;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    mop_d    = mop_q;
    neg_d    = neg_q;
    start    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (iter_needed) begin
            start   = 1'b1;
            mop_d   = op_dec;
            neg_d   = is_rem ? neg_a : (neg_a ^ neg_b);
            state_d = StBusy;
          end else begin
            result_d = imm_res;
            state_d  = StDone;
          end
        end
      end
      StBusy: begin
        if (iter_last) begin
          result_d = fix_res;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
      start    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      mop_q    <= OpAdd;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      mop_q    <= mop_d;
      neg_q    <= neg_d;
    end
  end

  mdu_iter #(
    .XLEN (XLEN)
  ) u_mdu_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .flush_i (flush),
    .div_i   (is_div),
    .a_i     (mag_a),
    .b_i     (mag_b),
    .last_o  (iter_last),
    .hi_o    (iter_hi),
    .lo_o    (iter_lo)
  );

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StBusy);
  assign result    = result_q;

endmodule
